ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
Two-port arbiter and sequencer that shares the single-port 32x8 synchronous LPM RAM (addr/clock/din/wren/dout) between two requesters, e.g. the switch-entry path and a display scanner. Each requester issues one read or write through a req/ack handshake. The block drives the RAM's address, data and write-enable from registers and returns read data. An optional post-reset sweep clears the whole RAM.

Parameters:
ADDR_W, 5, RAM address width (depth = 2**ADDR_W = 32)
DATA_W, 8, RAM data width
CLEAR_VAL, 0, word written by the clear sweep (width DATA_W)

Ports:
clock  in  1  system clock; the RAM uses the same clock
reset  in  1  synchronous, active-high reset
req0  in  1  requester 0 request; held high with we0/addr0/wdata0 stable until ack0
we0  in  1  requester 0: 1 = write, 0 = read
addr0  in  ADDR_W  requester 0 address
wdata0  in  DATA_W  requester 0 write data
ack0  out  1  one-cycle completion pulse to requester 0
req1, we1, addr1, wdata1, ack1: same as the port-0 signals, for requester 1
rdata  out  DATA_W  read data; valid in the ack cycle, held until the next ack
busy  out  1  high in any state other than IDLE
ram_addr  out  ADDR_W  registered RAM address
ram_din  out  DATA_W  registered RAM write data
ram_wren  out  1  registered RAM write enable
ram_dout  in  DATA_W  RAM read data, valid one clock after the address edge

Behaviour:
- Reset values: ack0 = ack1 = 0, rdata = 0, ram_addr = 0, ram_din = 0, ram_wren = 0, last = 1 (port 0 has priority first). State after reset: CLEAR if RAM_CLEAR_EN is defined, otherwise IDLE. busy is 1 in CLEAR and 0 in IDLE.
- States: CLEAR, IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - Sample req0/req1. If exactly one is high, grant it. If both are high, grant the port not equal to last.
  - On grant: register sel, ram_addr <= addrN, ram_din <= wdataN, ram_wren <= weN; go to ISSUE.
  - With no request, stay in IDLE with ram_wren = 0.
- ISSUE: RAM captures the address/data/wren at the end of this cycle. Next cycle: ram_wren <= 0; go to WAIT.
- WAIT: ram_dout is valid. For a read, rdata <= ram_dout. For a write, rdata holds its old value. Set ack[sel] <= 1 and last <= sel; go to ACK.
- ACK: ackN is high for exactly this cycle; go to IDLE.
- Latency: from req sampled high in IDLE (cycle 0), ack is high in cycle 3. Minimum spacing between grants is 4 cycles.
- Requester rule: the requester deasserts req in the cycle after ack. A req still high in IDLE after that is treated as a new request.
- Fairness: with both requests continuously asserted, grants strictly alternate (0,1,0,1,...).
- A req arriving while busy is not lost. It is sampled on the next IDLE cycle.
- Addresses wrap naturally within ADDR_W bits. No range check is performed.
- Reset asserted in any state: all outputs return to reset values on the next edge and any in-flight ack is suppressed. A write already clocked into the RAM in ISSUE is not undone.
- Only one of ack0/ack1 is ever high in a given cycle.

Optional Feature:
RAM_CLEAR_EN:
- Defined:
  - After reset the block enters CLEAR and drives ram_wren = 1, ram_din = CLEAR_VAL, with ram_addr counting 0..2**ADDR_W-1, one address per cycle.
  - After the last address it deasserts ram_wren and enters IDLE. The sweep takes 32 cycles plus 1 exit cycle.
  - No grants are issued during the sweep; busy = 1.
  - A reset during the sweep restarts it at address 0.
- Not defined: CLEAR does not exist and reset goes directly to IDLE. RAM contents are whatever the RAM initialisation provides.

Decomposition:
- Package ram_arbiter_pkg: state enum (CLEAR, IDLE, ISSUE, WAIT, ACK), default ADDR_W/DATA_W constants, and the port-select encoding (0/1).
- One natural sub-module, rr_arb2: two-way round-robin picker (inputs req0, req1, last; outputs grant_valid, grant_sel). Purely combinational.
- The FSM, RAM registers and clear counter stay in ram_arbiter.

Test Plan:
- Clear (RAM_CLEAR_EN defined): hold reset 2 cycles, release -> ram_wren = 1 for 32 cycles covering addresses 0..31, busy falls afterwards; reads of address 5 and address 31 both return 0x00.
- Single write then read: req0 write addr = 0x0A, data = 0xA5 -> ack0 in cycle 3. Then req0 read addr = 0x0A -> ack0 in cycle 3 with rdata = 0xA5; ack1 stays 0 throughout.
- Simultaneous requests from reset: req0 reads 0x01 and req1 reads 0x02 in the same cycle -> port 0 is served first, then port 1. Holding both requesters busy gives the grant order 0,1,0,1.
- Cross-port visibility: req1 writes 0x3C to address 0x1F, then req0 reads 0x1F -> rdata = 0x3C with ack0.
- Request during busy: req1 rises during port 0's WAIT cycle -> port 1 is granted on the first IDLE cycle, with ack1 exactly 4 cycles after port 0's ack.
- Reset mid-access: assert reset during WAIT of a read -> no ack pulse, rdata = 0 and ram_wren = 0 on the next edge; the FSM re-enters CLEAR or IDLE depending on RAM_CLEAR_EN.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// ============================================================================
// Module      : ram_arbiter_pkg
// Description : Shared types and constants for the two-port RAM arbiter:
//               FSM state encoding, default geometry and port-select codes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_arbiter_pkg;

  // Default RAM geometry: 32 words of 8 bits
  localparam int unsigned c_addr_w = 5;
  localparam int unsigned c_data_w = 8;

  // Port-select encoding used for sel/last/grant_sel
  localparam logic c_sel_port0 = 1'b0;
  localparam logic c_sel_port1 = 1'b1;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_IDLE  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_ACK   = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin picker. A lone request wins outright;
//               when both request, the port that was not served last wins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2
  import ram_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic grant_valid,
  output logic grant_sel
);

  // Pick a winner from the current requests and the last-served port
  always_comb begin
    grant_valid = req0 | req1;
    grant_sel   = c_sel_port0;
    if (req0 && req1) begin
      grant_sel = ~last;
    end else if (req1) begin
      grant_sel = c_sel_port1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ============================================================================
// Module      : ram_arbiter
// Description : Shares one single-port synchronous RAM between two
//               req/ack requesters. All RAM controls are registered; read
//               data is returned with a one-cycle ack pulse.
//               Build option: define RAM_CLEAR_EN to sweep the whole RAM
//               with CLEAR_VAL after every reset before serving requests.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned       ADDR_W    = c_addr_w,
  parameter int unsigned       DATA_W    = c_data_w,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_dout
);

`ifdef RAM_CLEAR_EN
  localparam state_t           c_reset_state = ST_CLEAR;
  // Counter value one past the last address: the sweep's exit cycle
  localparam logic [ADDR_W:0]  c_clr_end     = {1'b1, {ADDR_W{1'b0}}};
  logic [ADDR_W:0]             r_clr_cnt;
`else
  localparam state_t           c_reset_state = ST_IDLE;
`endif

  state_t              r_state;
  logic                r_sel;
  logic                r_we;
  logic                r_last;
  logic                r_ack0;
  logic                r_ack1;
  logic [DATA_W-1:0]   r_rdata;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_ram_din;
  logic                r_ram_wren;
  logic                w_grant_valid;
  logic                w_grant_sel;

  rr_arb2 u_rr_arb2 (
    .req0        (req0),
    .req1        (req1),
    .last        (r_last),
    .grant_valid (w_grant_valid),
    .grant_sel   (w_grant_sel)
  );

  // Sequencer: optional clear sweep, then grant -> issue -> wait -> ack
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= c_reset_state;
      r_sel      <= c_sel_port0;
      r_we       <= 1'b0;
      r_last     <= c_sel_port1;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_rdata    <= '0;
      r_ram_addr <= '0;
      r_ram_din  <= '0;
      r_ram_wren <= 1'b0;
`ifdef RAM_CLEAR_EN
      r_clr_cnt  <= '0;
`endif
    end else begin
      case (r_state)
        ST_CLEAR: begin
`ifdef RAM_CLEAR_EN
          if (r_clr_cnt == c_clr_end) begin
            r_ram_wren <= 1'b0;
            r_state    <= ST_IDLE;
          end else begin
            r_ram_wren <= 1'b1;
            r_ram_addr <= r_clr_cnt[ADDR_W-1:0];
            r_ram_din  <= CLEAR_VAL;
            r_clr_cnt  <= r_clr_cnt + 1'b1;
          end
`else
          // Unreachable without the sweep; fall back to IDLE safely
          r_ram_wren <= 1'b0;
          r_ram_din  <= CLEAR_VAL;
          r_state    <= ST_IDLE;
`endif
        end
        ST_IDLE: begin
          if (w_grant_valid) begin
            r_sel <= w_grant_sel;
            if (w_grant_sel == c_sel_port1) begin
              r_ram_addr <= addr1;
              r_ram_din  <= wdata1;
              r_ram_wren <= we1;
              r_we       <= we1;
            end else begin
              r_ram_addr <= addr0;
              r_ram_din  <= wdata0;
              r_ram_wren <= we0;
              r_we       <= we0;
            end
            r_state <= ST_ISSUE;
          end else begin
            r_ram_wren <= 1'b0;
          end
        end
        ST_ISSUE: begin
          // RAM has captured the access at this edge
          r_ram_wren <= 1'b0;
          r_state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!r_we) begin
            r_rdata <= ram_dout;
          end
          if (r_sel == c_sel_port1) begin
            r_ack1 <= 1'b1;
          end else begin
            r_ack0 <= 1'b1;
          end
          r_last  <= r_sel;
          r_state <= ST_ACK;
        end
        ST_ACK: begin
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack0     = r_ack0;
  assign ack1     = r_ack1;
  assign rdata    = r_rdata;
  assign busy     = (r_state != ST_IDLE);
  assign ram_addr = r_ram_addr;
  assign ram_din  = r_ram_din;
  assign ram_wren = r_ram_wren;

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ============================================================================
// Module      : tb_ram_arbiter
// Description : Self-checking bench for ram_arbiter with a behavioural RAM,
//               a transaction scoreboard and a memory reference model.
//               Honours RAM_CLEAR_EN in the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_arbiter;

  typedef struct {
    bit         we;
    logic [4:0] addr;
    logic [7:0] wdata;
  } txn_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [4:0] addr0 = '0, addr1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic       ack0, ack1, busy, ram_wren;
  logic [7:0] rdata, ram_din, ram_dout;
  logic [4:0] ram_addr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  txn_t q0[$];
  txn_t q1[$];
  int   ack_port [0:255];
  int   ack_cnt = 0;

`ifdef RAM_CLEAR_EN
  localparam logic c_busy_rst = 1'b1;
`else
  localparam logic c_busy_rst = 1'b0;
`endif

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  ram_arbiter #(.ADDR_W(5), .DATA_W(8), .CLEAR_VAL(8'h00)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .busy(busy),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_wren(ram_wren),
    .ram_dout(ram_dout)
  );

  // Power-up contents of the RAM, known to both the RAM and the model
  function automatic logic [7:0] init_val(input int i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  // Behavioural 32x8 synchronous RAM with registered read data
  logic [7:0] ram_mem [0:31];
  initial begin
    for (int i = 0; i < 32; i++) ram_mem[i] = init_val(i);
    forever begin
      @(posedge clock);
      if (ram_wren) ram_mem[ram_addr] = ram_din;
      ram_dout <= ram_mem[ram_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: memory model applied in ack order
  initial begin
    logic [7:0] ref_mem [0:31];
    logic [7:0] last_rdata;
    logic [7:0] exp_d;
    txn_t       t;
    int         p;
    for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);
    last_rdata = 8'h00;
    forever begin
      @(negedge clock);
      if (reset) begin
        last_rdata = 8'h00;
`ifdef RAM_CLEAR_EN
        for (int i = 0; i < 32; i++) ref_mem[i] = 8'h00;
`endif
      end else if (ack0 || ack1) begin
        checks++;
        if (ack0 && ack1) begin
          errors++;
          $display("FAIL ack_both ack0=%0b ack1=%0b exp=one-hot", ack0, ack1);
        end else begin
          p = ack0 ? 0 : 1;
          if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
            errors++;
            $display("FAIL unexpected_ack port=%0d got=ack exp=none t=%0t", p, $time);
          end else begin
            t = (p == 0) ? q0.pop_front() : q1.pop_front();
            exp_d = t.we ? last_rdata : ref_mem[t.addr];
            if (t.we) ref_mem[t.addr] = t.wdata;
            last_rdata = exp_d;
            chk($sformatf("rdata_p%0d_%s_a%0h", p, t.we ? "wr" : "rd", t.addr), rdata, exp_d);
          end
          if (ack_cnt < 256) ack_port[ack_cnt] = p;
          ack_cnt++;
        end
      end
    end
  end

  // One requester transaction; caller sits just after a rising edge
  task automatic run_req(input int port, input bit w, input logic [4:0] a,
                         input logic [7:0] d, output int lat, output int ack_at);
    txn_t t;
    t.we = w; t.addr = a; t.wdata = d;
    if (port == 0) begin
      q0.push_back(t); we0 = w; addr0 = a; wdata0 = d; req0 = 1'b1;
    end else begin
      q1.push_back(t); we1 = w; addr1 = a; wdata1 = d; req1 = 1'b1;
    end
    lat = -1; ack_at = -1;
    for (int n = 0; n < 24; n++) begin
      @(negedge clock);
      if ((port == 0 && ack0) || (port == 1 && ack1)) begin
        lat = n; ack_at = cyc;
        break;
      end
    end
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL ack_timeout port=%0d got=no-ack exp=ack", port);
    end
    @(posedge clock); #1;
    if (port == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Reset for two edges, check reset values, then follow the clear sweep
  task automatic do_reset();
    int idx;
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_din", ram_din, 0);
    chk("rst_ram_wren", ram_wren, 0);
    chk("rst_busy", busy, c_busy_rst);
    reset = 1'b0;
`ifdef RAM_CLEAR_EN
    idx = 0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clock);
      if (ram_wren) begin
        chk("clr_addr", ram_addr, idx);
        chk("clr_din", ram_din, 0);
        idx++;
      end else if (idx > 0) begin
        break;
      end
    end
    chk("clr_count", idx, 32);
    chk("clr_busy_fall", busy, 0);
`else
    idx = 0;
    @(negedge clock);
    chk("idle_busy", busy, 0);
    chk("idle_wren", ram_wren, idx);
`endif
    @(posedge clock); #1;
  endtask

  int la, lb, aa, ab, base;

  initial begin
    do_reset();

    // Write then read back on port 0
    run_req(0, 1'b1, 5'h0A, 8'hA5, la, aa);
    chk("wr_latency", la, 3);
    idle(1);
    run_req(0, 1'b0, 5'h0A, 8'h00, la, aa);
    chk("rd_latency", la, 3);
    chk("rd_value_a5", rdata, 8'hA5);
`ifdef RAM_CLEAR_EN
    idle(1);
    run_req(0, 1'b0, 5'h05, 8'h00, la, aa);
    chk("clr_rd5", rdata, 8'h00);
    run_req(1, 1'b0, 5'h1F, 8'h00, la, aa);
    chk("clr_rd31", rdata, 8'h00);
`endif

    // Simultaneous requests straight after reset: port 0 first
    do_reset();
    fork
      run_req(0, 1'b0, 5'h01, 8'h00, la, aa);
      run_req(1, 1'b0, 5'h02, 8'h00, lb, ab);
    join
    chk("simul_lat0", la, 3);
    chk("simul_lat1", lb, 7);

    // Both requests held high: grants alternate 0,1,0,1
    idle(1);
    base = ack_cnt;
    for (int i = 0; i < 2; i++) begin
      q0.push_back('{1'b0, 5'h03, 8'h00});
      q1.push_back('{1'b0, 5'h04, 8'h00});
    end
    we0 = 1'b0; addr0 = 5'h03; we1 = 1'b0; addr1 = 5'h04;
    req0 = 1'b1; req1 = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clock); #1;
      if (ack_cnt >= base + 4) break;
    end
    @(posedge clock); #1;
    req0 = 1'b0; req1 = 1'b0;
    chk("fair_count", ack_cnt - base, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("fair_order%0d", i), ack_port[base + i], i % 2);

    // Cross-port visibility
    idle(1);
    run_req(1, 1'b1, 5'h1F, 8'h3C, la, aa);
    idle(1);
    run_req(0, 1'b0, 5'h1F, 8'h00, la, aa);
    chk("xport_rdata", rdata, 8'h3C);

    // Request arriving during port 0's WAIT cycle
    idle(1);
    fork
      run_req(0, 1'b0, 5'h0A, 8'h00, la, aa);
      begin
        idle(2);
        run_req(1, 1'b0, 5'h1F, 8'h00, lb, ab);
      end
    join
    chk("busy_ack_gap", ab - aa, 4);

    // Reset during WAIT of a read suppresses the ack
    idle(1);
    we0 = 1'b0; addr0 = 5'h0A; req0 = 1'b1;
    idle(1);
    idle(1);
    reset = 1'b1; req0 = 1'b0;
    idle(1);
    chk("midrst_ack0", ack0, 0);
    chk("midrst_rdata", rdata, 0);
    chk("midrst_wren", ram_wren, 0);
    chk("midrst_busy", busy, c_busy_rst);
    do_reset();

    // Randomised traffic from both ports on a small address window
    fork
      for (int i = 0; i < 20; i++) begin
        int l, c;
        idle($urandom_range(0, 3));
        run_req(0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 8'($urandom), l, c);
        checks++;
        if (l < 3 || l > 7) begin
          errors++;
          $display("FAIL rand_lat0 got=%0d exp=3..7", l);
        end
      end
      for (int i = 0; i < 20; i++) begin
        int l, c;
        idle($urandom_range(0, 3));
        run_req(1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 8'($urandom), l, c);
        checks++;
        if (l < 3 || l > 7) begin
          errors++;
          $display("FAIL rand_lat1 got=%0d exp=3..7", l);
        end
      end
    join
    idle(4);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
